// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA bus-master engine.
// DMA_BYTE_SWAP_EN selects byte-reversed data words in the top module.
package dma_pkg;

    localparam int LENGTH_W = 10;
    localparam logic [3:0] BYTE_ENABLE_ALL = 4'hF;
    localparam logic DIR_READ = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQUEST,
        S_BEGIN,
        S_READ_DATA,
        S_WRITE_PREFETCH,
        S_WRITE_DATA,
        S_END_WR,
        S_NEXT,
        S_DONE
    } dmaState_e;

    function automatic logic [31:0] byteSwap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min(remaining, BURST_MAX) and its words-1 encoding.
// Pure combinational helper for dma_bus_master.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int BURST_MAX = 16
) (
    input  logic [LENGTH_W-1:0] remaining,
    output logic [LENGTH_W-1:0] burstLen,
    output logic [7:0]          burstSize
);

    localparam logic [LENGTH_W-1:0] MAX_LEN = LENGTH_W'(BURST_MAX);

    always_comb begin
        burstLen  = (remaining > MAX_LEN) ? MAX_LEN : remaining;
        burstSize = 8'(burstLen - LENGTH_W'(1));
    end

endmodule

// File: rtl/dma_bus_master.sv
// DMA bus-master: moves words between the system bus and the local buffer.
// Define DMA_BYTE_SWAP_EN to byte-reverse data words in both directions.
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int BURST_MAX  = 16,
    parameter int BUF_ADDR_W = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_start,
    input  logic [31:0]           req_bus_addr,
    input  logic [BUF_ADDR_W-1:0] req_buf_addr,
    input  logic [LENGTH_W-1:0]   req_length,
    input  logic                  req_read,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  request_out,
    input  logic                  granted_in,
    output logic                  begin_transaction_out,
    output logic [31:0]           address_data_out,
    input  logic [31:0]           address_data_in,
    output logic [3:0]            byte_enables_out,
    output logic [7:0]            burst_size_out,
    output logic                  read_n_write_out,
    output logic                  end_transaction_out,
    input  logic                  end_transaction_in,
    output logic                  data_valid_out,
    input  logic                  data_valid_in,
    input  logic                  busy_in,
    input  logic                  error_in,
    output logic [BUF_ADDR_W-1:0] buf_addr_out,
    output logic                  buf_we_out,
    output logic [31:0]           buf_wdata_out,
    input  logic [31:0]           buf_rdata_in
);

    dmaState_e state, stateNext;

    logic [29:0]           busWord;
    logic [BUF_ADDR_W-1:0] bufAddr;
    logic [LENGTH_W-1:0]   remaining;
    logic [LENGTH_W-1:0]   wordCnt;
    logic [LENGTH_W-1:0]   burstLen;
    logic [7:0]            burstSize;
    logic                  isRead;
    logic                  errorReg;
    logic                  fresh;
    logic [31:0]           holdReg;
    logic [31:0]           wordOut;
    logic [31:0]           wrSwapped;
    logic [31:0]           rdSwapped;
    logic                  writeState;
    logic                  busState;
    logic                  advance;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^req_bus_addr[1:0];

    dma_burst_calc #(
        .BURST_MAX(BURST_MAX)
    ) uBurstCalc (
        .remaining(remaining),
        .burstLen (burstLen),
        .burstSize(burstSize)
    );

    // Fresh buffer data on the cycle after a read; latched copy during stalls.
    assign wordOut = fresh ? buf_rdata_in : holdReg;

`ifdef DMA_BYTE_SWAP_EN
    assign wrSwapped = byteSwap(wordOut);
    assign rdSwapped = byteSwap(address_data_in);
`else
    assign wrSwapped = wordOut;
    assign rdSwapped = address_data_in;
`endif

    assign writeState = (state == S_WRITE_PREFETCH) ||
                        (state == S_WRITE_DATA) ||
                        (state == S_END_WR);
    assign busState = writeState ||
                      (state == S_BEGIN) ||
                      (state == S_READ_DATA);
    assign advance = (state == S_WRITE_DATA) && !busy_in && !error_in;

    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE:           if (req_start) stateNext = S_NEXT;
            S_REQUEST:        if (granted_in) stateNext = S_BEGIN;
            S_BEGIN:          stateNext = isRead ? S_READ_DATA : S_WRITE_PREFETCH;
            S_READ_DATA:      if (end_transaction_in) stateNext = S_NEXT;
            S_WRITE_PREFETCH: stateNext = S_WRITE_DATA;
            S_WRITE_DATA: begin
                if (advance && wordCnt == LENGTH_W'(1)) stateNext = S_END_WR;
            end
            S_END_WR:         stateNext = S_NEXT;
            S_NEXT:           stateNext = (remaining != '0) ? S_REQUEST : S_DONE;
            S_DONE:           stateNext = S_IDLE;
            default:          stateNext = S_IDLE;
        endcase
        if (busState && error_in) stateNext = S_DONE;
    end

    always_comb begin
        request_out           = (state == S_REQUEST);
        begin_transaction_out = (state == S_BEGIN);
        address_data_out      = '0;
        byte_enables_out      = '0;
        burst_size_out        = '0;
        if (state == S_BEGIN) begin
            address_data_out = {busWord, 2'b00};
            byte_enables_out = BYTE_ENABLE_ALL;
            burst_size_out   = burstSize;
        end else if (state == S_WRITE_DATA) begin
            address_data_out = wrSwapped;
        end
        read_n_write_out    = (busState && isRead) ? DIR_READ : DIR_WRITE;
        end_transaction_out = (state == S_END_WR) || (writeState && error_in);
        data_valid_out      = (state == S_WRITE_DATA) && !error_in;
        buf_addr_out        = '0;
        if (state == S_READ_DATA || state == S_WRITE_PREFETCH ||
            state == S_WRITE_DATA) begin
            buf_addr_out = bufAddr;
        end
        buf_we_out    = (state == S_READ_DATA) && data_valid_in && !error_in;
        buf_wdata_out = buf_we_out ? rdSwapped : '0;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        error         = errorReg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            busWord   <= '0;
            bufAddr   <= '0;
            remaining <= '0;
            wordCnt   <= '0;
            isRead    <= 1'b0;
            errorReg  <= 1'b0;
            fresh     <= 1'b0;
            holdReg   <= '0;
        end else begin
            state <= stateNext;
            unique case (state)
                S_IDLE: begin
                    if (req_start) begin
                        busWord   <= req_bus_addr[31:2];
                        bufAddr   <= req_buf_addr;
                        remaining <= req_length;
                        isRead    <= (req_read == DIR_READ);
                        errorReg  <= 1'b0;
                    end
                end
                S_BEGIN: begin
                    wordCnt   <= burstLen;
                    busWord   <= busWord + 30'(burstLen);
                    remaining <= remaining - burstLen;
                end
                S_READ_DATA: begin
                    if (buf_we_out) bufAddr <= bufAddr + BUF_ADDR_W'(1);
                end
                S_WRITE_PREFETCH: begin
                    bufAddr <= bufAddr + BUF_ADDR_W'(1);
                    fresh   <= 1'b1;
                end
                S_WRITE_DATA: begin
                    holdReg <= wordOut;
                    fresh   <= 1'b0;
                    // Issue the next buffer read as the current word is taken.
                    if (advance && wordCnt > LENGTH_W'(1)) begin
                        bufAddr <= bufAddr + BUF_ADDR_W'(1);
                        wordCnt <= wordCnt - LENGTH_W'(1);
                        fresh   <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (busState && error_in) errorReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_bus_master.sv
// Scoreboard bench for dma_bus_master with a bus slave and buffer model.
// Honours DMA_BYTE_SWAP_EN when the design is built with it.
module tb_dma_bus_master;

    logic        clock;
    logic        reset;
    logic        req_start;
    logic [31:0] req_bus_addr;
    logic [8:0]  req_buf_addr;
    logic [9:0]  req_length;
    logic        req_read;
    logic        busy, done, error;
    logic        request_out;
    logic        granted_in;
    logic        begin_transaction_out;
    logic [31:0] address_data_out;
    logic [31:0] address_data_in;
    logic [3:0]  byte_enables_out;
    logic [7:0]  burst_size_out;
    logic        read_n_write_out;
    logic        end_transaction_out;
    logic        end_transaction_in;
    logic        data_valid_out;
    logic        data_valid_in;
    logic        busy_in;
    logic        error_in;
    logic [8:0]  buf_addr_out;
    logic        buf_we_out;
    logic [31:0] buf_wdata_out;
    logic [31:0] buf_rdata_in;

    dma_bus_master #(
        .BURST_MAX (16),
        .BUF_ADDR_W(9)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_start            (req_start),
        .req_bus_addr         (req_bus_addr),
        .req_buf_addr         (req_buf_addr),
        .req_length           (req_length),
        .req_read             (req_read),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .request_out          (request_out),
        .granted_in           (granted_in),
        .begin_transaction_out(begin_transaction_out),
        .address_data_out     (address_data_out),
        .address_data_in      (address_data_in),
        .byte_enables_out     (byte_enables_out),
        .burst_size_out       (burst_size_out),
        .read_n_write_out     (read_n_write_out),
        .end_transaction_out  (end_transaction_out),
        .end_transaction_in   (end_transaction_in),
        .data_valid_out       (data_valid_out),
        .data_valid_in        (data_valid_in),
        .busy_in              (busy_in),
        .error_in             (error_in),
        .buf_addr_out         (buf_addr_out),
        .buf_we_out           (buf_we_out),
        .buf_wdata_out        (buf_wdata_out),
        .buf_rdata_in         (buf_rdata_in)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  size;
        logic        rnw;
    } beginExp_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } bufExp_t;

    beginExp_t   expBegin[$];
    bufExp_t     expBufWr[$];
    logic [31:0] expWr[$];
    logic        expDone[$];
    logic [31:0] rdWords[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int doneCount = 0, doneCyc = 0;
    int endCount = 0, endCyc = 0;
    int reqCount = 0, bufWrCount = 0;
    int lastAcceptCyc = 0;

    int rdLeft = 0, rdIdx = 0, errAt = -1;
    int wrIdx = 0, stallIdx = -1, stallLeft = 0;

    logic [31:0] mem [512];
    logic        preWe;
    logic [8:0]  preAddr;
    logic [31:0] preData;

    function automatic logic [31:0] swapIf(input logic [31:0] w);
`ifdef DMA_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (preWe) mem[preAddr] <= preData;
        else if (buf_we_out) mem[buf_addr_out] <= buf_wdata_out;
        buf_rdata_in <= mem[buf_addr_out];
    end

    // Bus slave: grants immediately, streams read data, stalls writes on demand.
    initial begin
        granted_in = 0;
        data_valid_in = 0;
        end_transaction_in = 0;
        error_in = 0;
        busy_in = 0;
        address_data_in = 0;
        forever begin
            @(negedge clock);
            granted_in = request_out;
            data_valid_in = 0;
            end_transaction_in = 0;
            error_in = 0;
            busy_in = 0;
            address_data_in = 0;
            if (rdLeft > 0) begin
                if (rdIdx == errAt) begin
                    error_in = 1;
                    rdLeft = 0;
                end else begin
                    data_valid_in = 1;
                    address_data_in = (rdWords.size() > 0) ? rdWords.pop_front() : 32'hDEAD0000;
                    end_transaction_in = (rdLeft == 1);
                    rdLeft--;
                    rdIdx++;
                end
            end else if (data_valid_out) begin
                if (wrIdx == stallIdx && stallLeft > 0) begin
                    busy_in = 1;
                    stallLeft--;
                end else begin
                    wrIdx++;
                end
            end
            if (begin_transaction_out && read_n_write_out)
                rdLeft = int'(burst_size_out) + 1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        bit          stallPrev;
        logic [31:0] heldWord;
        stallPrev = 0;
        heldWord = 0;
        forever begin
            @(negedge clock);
            #1;
            if (begin_transaction_out) begin
                if (expBegin.size() == 0) failNow("beginUnexpected");
                else begin
                    beginExp_t e;
                    e = expBegin.pop_front();
                    check("beginAddr", address_data_out, e.addr);
                    check("beginSize", {24'h0, burst_size_out}, {24'h0, e.size});
                    check("beginDir", {31'h0, read_n_write_out}, {31'h0, e.rnw});
                    check("beginBe", {28'h0, byte_enables_out}, 32'hF);
                end
            end
            if (buf_we_out) begin
                bufWrCount++;
                if (expBufWr.size() == 0) failNow("bufWrUnexpected");
                else begin
                    bufExp_t b;
                    b = expBufWr.pop_front();
                    check("bufWrAddr", {23'h0, buf_addr_out}, {23'h0, b.addr});
                    check("bufWrData", buf_wdata_out, b.data);
                end
            end
            if (stallPrev && data_valid_out)
                check("holdData", address_data_out, heldWord);
            stallPrev = data_valid_out && busy_in;
            heldWord = address_data_out;
            if (data_valid_out && !busy_in) begin
                lastAcceptCyc = cyc;
                if (expWr.size() == 0) failNow("wrUnexpected");
                else check("wrData", address_data_out, expWr.pop_front());
            end
            if (end_transaction_out) begin
                endCount++;
                endCyc = cyc;
            end
            if (request_out) reqCount++;
            if (done) begin
                doneCount++;
                doneCyc = cyc;
                if (expDone.size() == 0) failNow("doneUnexpected");
                else check("doneError", {31'h0, error}, {31'h0, expDone.pop_front()});
            end
        end
    end

    task automatic loadMem(input logic [8:0] a, input logic [31:0] d);
        @(negedge clock);
        preWe = 1;
        preAddr = a;
        preData = d;
        @(negedge clock);
        preWe = 0;
    endtask

    task automatic startXfer(input logic [31:0] ba, input logic [8:0] bf,
                             input logic [9:0] len, input logic rd,
                             output int startCyc);
        @(negedge clock);
        req_bus_addr = ba;
        req_buf_addr = bf;
        req_length = len;
        req_read = rd;
        req_start = 1;
        startCyc = cyc;
        @(negedge clock);
        req_start = 0;
    endtask

    task automatic waitDone(input int target, input int limit);
        int n;
        n = 0;
        while (doneCount < target && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (doneCount < target) failNow("doneTimeout");
        @(negedge clock);
        #2;
    endtask

    initial begin
        int sc;
        int d0, e0, r0, w0;
        logic [31:0] swapCheck;
`ifdef DMA_BYTE_SWAP_EN
        swapCheck = 32'h44332211;
`else
        swapCheck = 32'h11223344;
`endif
        reset = 1;
        req_start = 0;
        req_bus_addr = 0;
        req_buf_addr = 0;
        req_length = 0;
        req_read = 0;
        preWe = 0;
        preAddr = 0;
        preData = 0;
        repeat (3) @(negedge clock);
        #2;
        check("rstBusy", {31'h0, busy}, 0);
        check("rstDone", {31'h0, done}, 0);
        check("rstError", {31'h0, error}, 0);
        check("rstReq", {31'h0, request_out}, 0);
        check("rstAddrData", address_data_out, 0);
        check("rstBufAddr", {23'h0, buf_addr_out}, 0);
        check("rstMisc", {24'h0, byte_enables_out, begin_transaction_out,
                          end_transaction_out, data_valid_out, buf_we_out}, 0);
        @(negedge clock);
        reset = 0;

        // Read len=5: one burst, first word doubles as the swap check.
        rdWords.delete();
        rdIdx = 0;
        errAt = -1;
        rdWords.push_back(32'h11223344);
        for (int i = 1; i < 5; i++) rdWords.push_back(32'hA0000000 + i);
        expBegin.push_back('{32'h00001000, 8'd4, 1'b1});
        expBufWr.push_back('{9'h010, swapCheck});
        for (int i = 1; i < 5; i++)
            expBufWr.push_back('{9'(9'h010 + i), swapIf(32'hA0000000 + i)});
        expDone.push_back(1'b0);
        startXfer(32'h00001000, 9'h010, 10'd5, 1'b1, sc);
        waitDone(1, 200);
        check("t1Busy", {31'h0, busy}, 0);
        check("t1Error", {31'h0, error}, 0);

        // Read len=40: bursts of 16, 16, 8.
        rdWords.delete();
        rdIdx = 0;
        for (int i = 0; i < 40; i++) begin
            rdWords.push_back(32'h20000000 + i);
            expBufWr.push_back('{9'(9'h100 + i), swapIf(32'h20000000 + i)});
        end
        expBegin.push_back('{32'h00001000, 8'd15, 1'b1});
        expBegin.push_back('{32'h00001040, 8'd15, 1'b1});
        expBegin.push_back('{32'h00001080, 8'd7, 1'b1});
        expDone.push_back(1'b0);
        startXfer(32'h00001000, 9'h100, 10'd40, 1'b1, sc);
        waitDone(2, 400);
        check("t2Busy", {31'h0, busy}, 0);

        // Write len=4 wrapping the buffer, 2-cycle stall on word 2.
        loadMem(9'h1FE, 32'hCAFE0000);
        loadMem(9'h1FF, 32'hCAFE0001);
        loadMem(9'h000, 32'hCAFE0002);
        loadMem(9'h001, 32'hCAFE0003);
        wrIdx = 0;
        stallIdx = 2;
        stallLeft = 2;
        for (int i = 0; i < 4; i++) expWr.push_back(swapIf(32'hCAFE0000 + i));
        expBegin.push_back('{32'h00002000, 8'd3, 1'b0});
        expDone.push_back(1'b0);
        e0 = endCount;
        startXfer(32'h00002000, 9'h1FE, 10'd4, 1'b0, sc);
        waitDone(3, 200);
        check("t3EndCount", endCount - e0, 1);
        check("t3EndAfterLast", endCyc - lastAcceptCyc, 1);
        check("t3StallUsed", stallLeft, 0);
        stallIdx = -1;

        // Read len=8 with error_in on the 3rd word.
        rdWords.delete();
        rdIdx = 0;
        errAt = 2;
        for (int i = 0; i < 8; i++) rdWords.push_back(32'h30000000 + i);
        expBufWr.push_back('{9'h040, swapIf(32'h30000000)});
        expBufWr.push_back('{9'h041, swapIf(32'h30000001)});
        expBegin.push_back('{32'h00003000, 8'd7, 1'b1});
        expDone.push_back(1'b1);
        w0 = bufWrCount;
        startXfer(32'h00003000, 9'h040, 10'd8, 1'b1, sc);
        waitDone(4, 200);
        errAt = -1;
        check("t4BufWrites", bufWrCount - w0, 2);
        check("t4ErrorSticky", {31'h0, error}, 1);
        check("t4Busy", {31'h0, busy}, 0);

        // Zero length, plus a start while busy that must be dropped.
        d0 = doneCount;
        r0 = reqCount;
        expDone.push_back(1'b0);
        @(negedge clock);
        req_bus_addr = 32'h00004000;
        req_buf_addr = 9'h080;
        req_length = 10'd0;
        req_read = 1'b1;
        req_start = 1;
        sc = cyc;
        @(negedge clock);
        #2;
        check("t5ErrorCleared", {31'h0, error}, 0);
        check("t5BusyNext", {31'h0, busy}, 1);
        req_length = 10'd5;
        req_start = 1;
        @(negedge clock);
        req_start = 0;
        repeat (12) @(negedge clock);
        #2;
        check("t5DoneCount", doneCount - d0, 1);
        check("t5DoneLatency", doneCyc - sc, 2);
        check("t5NoRequest", reqCount - r0, 0);
        check("t5Busy", {31'h0, busy}, 0);

        check("queuesEmpty", expBegin.size() + expBufWr.size() +
                             expWr.size() + expDone.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
